mult_div: RTL and testbench
===========================

Name: mult_div

Overview:
- Iterative signed multiply/divide unit that owns the HI and LO registers.
- Started by the multicycle control unit for R-type mult (funct 0x18) and div (funct 0x1A).
- Takes regA_out/regB_out as operands and sends HI_out/LO_out to the MEMtoReg mux for mfhi/mflo.
- The control unit holds in a wait state while busy is high and resumes on done.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start_mult  in  1  one-cycle request: signed A_in*B_in.
- start_div  in  1  one-cycle request: signed A_in/B_in.
- A_in  in  DATA_W  operand A (multiplicand / dividend), sampled only on an accepted start.
- B_in  in  DATA_W  operand B (multiplier / divisor), sampled only on an accepted start.
- HI_out  out  DATA_W  mult: upper product word; div: remainder.
- LO_out  out  DATA_W  mult: lower product word; div: quotient.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse, concurrent with done, when the divisor was 0.

Behaviour:
- Clocking and reset
  - All state updates on posedge clk.
  - When reset is high at an edge: state=IDLE, counter=0, HI_out=0, LO_out=0, busy=0, done=0, div_zero=0. This applies mid-operation as well; any partial result is discarded.
- States: IDLE, MULT, DIV, FIXUP, FINISH.
- IDLE
  - start_mult sampled high: latch |A|, |B| and the result sign (A[31]^B[31]); clear the accumulator; counter=0; go to MULT.
  - start_div sampled high with B_in!=0: latch |A|, |B|, quotient sign (A[31]^B[31]) and remainder sign (A[31]); go to DIV.
  - start_div with B_in==0: go to FINISH with div_zero flagged. HI/LO are unchanged.
  - Both starts high together: treated as mult.
  - Starts are accepted only in IDLE. Starts arriving in any other state are ignored, with no queueing.
- MULT
  - Unsigned shift-add, one multiplier bit per cycle, for DATA_W cycles.
  - On the edge where counter==DATA_W-1, go to FIXUP.
- DIV
  - Unsigned restoring division, one quotient bit per cycle, for DATA_W cycles, then FIXUP.
- FIXUP (one cycle)
  - mult: apply two's-complement negation to the full 2*DATA_W product if the sign is set. Write HI=upper word, LO=lower word.
  - div: negate the quotient if the quotient sign is set and negate the remainder if the remainder sign is set. Write LO=quotient, HI=remainder.
  - Go to FINISH.
- FINISH (one cycle): done=1, plus div_zero=1 if flagged; return to IDLE.
- Outputs
  - busy=1 in MULT, DIV and FIXUP; busy=0 in FINISH.
  - done, div_zero and busy are decoded from registered state, so they are glitch-free.
- Latency
  - Start high in cycle c gives done high in cycle c+34 (c+1 MULT/DIV entry, 32 iterations, FIXUP, FINISH).
  - Div-by-zero gives done/div_zero in cycle c+1.
- Result timing
  - HI/LO change only at the FIXUP edge and are stable from the done cycle onward until the next completion.
  - HI/LO are never exposed mid-computation.
- Arithmetic rules
  - Absolute value of 0x80000000 is 0x80000000 as unsigned.
  - 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. Overflow is not flagged.
  - Remainder sign follows the dividend, giving MIPS truncation semantics.

Decomposition:
- Shared package mult_div_pkg:
  - State encoding constants.
  - Funct constants FUNCT_MULT=6'h18, FUNCT_DIV=6'h1A, FUNCT_MFHI=6'h10, FUNCT_MFLO=6'h12, shared with the control unit.
  - Latency constant MD_LATENCY=34.
- Single module; no sub-module is natural.
- Datapath: one 2*DATA_W shift register reused for the product, and for remainder:quotient during division.

Test Plan:
- Signed multiply: reset, then start_mult with A=7, B=0xFFFFFFFD (-3) -> busy high cycles c+1..c+33; done pulse at c+34; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Signed divide, negative dividend: start_div with A=0xFFFFFFF9 (-7), B=2 -> at c+34, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1), div_zero=0.
- Most-negative operands: start_mult with A=B=0x80000000 -> HI=0x40000000, LO=0. Then start_div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: prior HI=0x12345678, LO=0x9ABCDEF0; start_div with B=0 -> done=div_zero=1 in cycle c+1 only; busy stays 0; HI/LO unchanged.
- Busy protection and reset: a start_div pulse at c+5 during a mult is ignored and the mult result is correct at c+34. A second run with reset at c+10 -> next cycle all outputs 0, state IDLE, no done pulse follows, and a new start is then accepted normally.

Source files
------------

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: state encoding, funct codes and latency shared with the control unit
package mult_div_pkg;
   typedef enum logic [2:0] {IDLE, MULT, DIV, FIXUP, FINISH} state_t;
   localparam logic [5:0] FUNCT_MULT = 6'h18;
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;
   localparam logic [5:0] FUNCT_MFHI = 6'h10;
   localparam logic [5:0] FUNCT_MFLO = 6'h12;
   localparam int MD_LATENCY = 34;
endpackage

// File: rtl/mult_div.sv
// mult_div: iterative signed multiply/divide owning HI/LO
// one 2*DATA_W register holds the product, or remainder:quotient during division
module mult_div
   import mult_div_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_mult,
   input  logic              start_div,
   input  logic [DATA_W-1:0] A_in,
   input  logic [DATA_W-1:0] B_in,
   output logic [DATA_W-1:0] HI_out,
   output logic [DATA_W-1:0] LO_out,
   output logic              busy,
   output logic              done,
   output logic              div_zero
);
   localparam int W = DATA_W;
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [2*W-1:0] acc, prod;
   logic [W-1:0] opnd, abs_a, abs_b, quo_f, rem_f;
   logic [W:0] sum, top, diff;
   logic sign_q, sign_r, op_div, dz, last;
   always_comb begin
      abs_a = A_in[W-1] ? -A_in : A_in;
      abs_b = B_in[W-1] ? -B_in : B_in;
      sum   = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
      top   = acc[2*W-1:W-1];
      diff  = top - {1'b0, opnd};
      prod  = sign_q ? -acc : acc;
      quo_f = sign_q ? -acc[W-1:0] : acc[W-1:0];
      rem_f = sign_r ? -acc[2*W-1:W] : acc[2*W-1:W];
      last  = cnt == CNT_W'(W-1);
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = start_mult ? MULT : start_div ? (B_in == '0 ? FINISH : DIV) : IDLE;
         MULT, DIV: state_nx = last ? FIXUP : state;
         FIXUP:     state_nx = FINISH;
         default:   state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         HI_out <= '0;
         LO_out <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         op_div <= 1'b0;
         dz     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (start_mult || start_div) begin
                  dz     <= !start_mult && B_in == '0;
                  op_div <= !start_mult;
                  sign_q <= A_in[W-1] ^ B_in[W-1];
                  sign_r <= A_in[W-1];
                  opnd   <= start_mult ? abs_a : abs_b;
                  acc    <= {{W{1'b0}}, start_mult ? abs_b : abs_a};
               end
            end
            MULT: begin
               acc <= acc[0] ? {sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
               cnt <= cnt + 1'b1;
            end
            DIV: begin
               // a clear borrow bit means the trial subtraction fits: keep it, quotient bit 1
               acc <= diff[W] ? {top[W-1:0], acc[W-2:0], 1'b0} : {diff[W-1:0], acc[W-2:0], 1'b1};
               cnt <= cnt + 1'b1;
            end
            FIXUP: {HI_out, LO_out} <= op_div ? {rem_f, quo_f} : prod;
            default: ;
         endcase
      end
   end
   assign busy     = state == MULT || state == DIV || state == FIXUP;
   assign done     = state == FINISH;
   assign div_zero = state == FINISH && dz;
endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed vectors, expected results queued at issue and checked on done
module tb_mult_div;
   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          due;
   } exp_t;
   logic clk = 0, reset = 1, start_mult = 0, start_div = 0;
   logic [31:0] A_in = 0, B_in = 0, HI_out, LO_out;
   logic busy, done, div_zero;
   int cyc = 0, checks = 0, errors = 0;
   exp_t q[$];
   mult_div dut (
      .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
      .A_in(A_in), .B_in(B_in), .HI_out(HI_out), .LO_out(LO_out),
      .busy(busy), .done(done), .div_zero(div_zero)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask
   always @(negedge clk)
      if (!reset && done) begin
         if (q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("HI", HI_out, e.hi);
            chk("LO", LO_out, e.lo);
            chk("div_zero", div_zero, e.dz);
            chk("latency", cyc, e.due);
         end
      end
   task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] b, input logic push,
                        input logic [31:0] hi, input logic [31:0] lo, input logic dz, input int lat);
      @(negedge clk);
      start_mult = m;
      start_div  = !m;
      A_in = a;
      B_in = b;
      if (push) q.push_back('{hi: hi, lo: lo, dz: dz, due: cyc + lat});
      @(negedge clk);
      start_mult = 0;
      start_div  = 0;
   endtask
   task automatic drain();
      int t = 0;
      while (q.size() > 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (q.size() > 0) begin
         chk("timeout", q.size(), 0);
         q.delete();
      end
      repeat (3) @(negedge clk);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      reset = 0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", div_zero, 0);
      chk("rst_hilo", {HI_out, LO_out}, 0);
      issue(1, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34);
      for (int i = 1; i <= 34; i++) begin
         chk($sformatf("busy_c%0d", i), busy, i <= 33);
         if (i < 34) @(negedge clk);
      end
      drain();
      issue(0, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34);
      drain();
      issue(0, 32'd1234, 32'd0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 1);
      chk("dz_busy", busy, 0);
      drain();
      issue(1, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h0, 0, 34);
      drain();
      issue(0, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 0, 34);
      drain();
      issue(1, 32'd12345, 32'hFFFFFF9C, 1, 32'hFFFFFFFF, 32'hFFED29BC, 0, 34);
      repeat (4) @(negedge clk);
      start_div = 1;
      A_in = 32'd100;
      B_in = 32'd7;
      @(negedge clk);
      start_div = 0;
      drain();
      repeat (40) @(negedge clk);
      issue(1, 32'd9, 32'd11, 0, 0, 0, 0, 0);
      repeat (9) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_dz", div_zero, 0);
      chk("mid_rst_hilo", {HI_out, LO_out}, 0);
      repeat (40) @(negedge clk);
      chk("post_rst_busy", busy, 0);
      issue(1, 32'd3, 32'd5, 1, 32'h0, 32'd15, 0, 34);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
